// File: rtl/ddr2_sys_st_channel_pkt_adapter.sv
// Avalon-ST channel adapter: drops whole packets whose SOP channel exceeds MAX_CHANNEL and
// forwards the rest through a two-entry skid buffer. Counters built only with ST_CHAN_ADAPT_DROP_CNT_EN.
module ddr2_sys_st_channel_pkt_adapter #(
    parameter int DATA_W        = 8,
    parameter int IN_CHANNEL_W  = 8,
    parameter int OUT_CHANNEL_W = 2,
    parameter int MAX_CHANNEL   = 3,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         orphan_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [IN_CHANNEL_W-1:0] MAX_CH = IN_CHANNEL_W'(MAX_CHANNEL);

    logic [1:0]               state_reg, state_next;
    logic [OUT_CHANNEL_W-1:0] chan_reg, chan_next;

    logic                     out_valid_reg;
    logic [DATA_W-1:0]        out_data_reg;
    logic [OUT_CHANNEL_W-1:0] out_chan_reg;
    logic                     out_sop_reg, out_eop_reg;

    logic                     skid_valid_reg;
    logic [DATA_W-1:0]        skid_data_reg;
    logic [OUT_CHANNEL_W-1:0] skid_chan_reg;
    logic                     skid_sop_reg, skid_eop_reg;

    logic                     accept, chan_ok, push, load_out;
    logic [OUT_CHANNEL_W-1:0] beat_chan;

    // DROP is only entered from a cycle where the skid slot was empty and
    // never pushes, so forcing in_ready high there cannot overflow the buffer.
    assign in_ready = (state_reg == ST_DROP) | ~skid_valid_reg;
    assign accept   = in_valid & in_ready;
    assign chan_ok  = (in_channel <= MAX_CH);
    assign load_out = ~out_valid_reg | out_ready;

    always_comb begin
        state_next = state_reg;
        chan_next  = chan_reg;
        push       = 1'b0;
        beat_chan  = chan_reg;
        if (accept) begin
            if (in_startofpacket) begin
                if (chan_ok) begin
                    push       = 1'b1;
                    chan_next  = in_channel[OUT_CHANNEL_W-1:0];
                    beat_chan  = in_channel[OUT_CHANNEL_W-1:0];
                    state_next = in_endofpacket ? ST_IDLE : ST_PASS;
                end else begin
                    state_next = in_endofpacket ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (state_reg)
                    ST_PASS: begin
                        push = 1'b1;
                        if (in_endofpacket) state_next = ST_IDLE;
                    end
                    ST_DROP: begin
                        if (in_endofpacket) state_next = ST_IDLE;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            chan_reg  <= '0;
        end else begin
            state_reg <= state_next;
            chan_reg  <= chan_next;
        end
    end

    // A push never meets a full skid slot: in_ready is ~skid_valid whenever pushes can occur.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_chan_reg   <= '0;
            out_sop_reg    <= 1'b0;
            out_eop_reg    <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_chan_reg  <= '0;
            skid_sop_reg   <= 1'b0;
            skid_eop_reg   <= 1'b0;
        end else if (load_out) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                out_chan_reg   <= skid_chan_reg;
                out_sop_reg    <= skid_sop_reg;
                out_eop_reg    <= skid_eop_reg;
                skid_valid_reg <= 1'b0;
            end else if (push) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= in_data;
                out_chan_reg  <= beat_chan;
                out_sop_reg   <= in_startofpacket;
                out_eop_reg   <= in_endofpacket;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (push) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
            skid_chan_reg  <= beat_chan;
            skid_sop_reg   <= in_startofpacket;
            skid_eop_reg   <= in_endofpacket;
        end
    end

    assign out_valid         = out_valid_reg;
    assign out_data          = out_data_reg;
    assign out_channel       = out_chan_reg;
    assign out_startofpacket = out_sop_reg;
    assign out_endofpacket   = out_eop_reg;

`ifdef ST_CHAN_ADAPT_DROP_CNT_EN
    logic             drop_evt, orphan_evt;
    logic [CNT_W-1:0] drop_cnt_reg, orphan_cnt_reg;

    assign drop_evt   = accept & in_startofpacket & ~chan_ok;
    assign orphan_evt = accept & ~in_startofpacket & (state_reg == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg   <= '0;
            orphan_cnt_reg <= '0;
        end else begin
            if (drop_evt && drop_cnt_reg != {CNT_W{1'b1}})
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            if (orphan_evt && orphan_cnt_reg != {CNT_W{1'b1}})
                orphan_cnt_reg <= orphan_cnt_reg + CNT_W'(1);
        end
    end

    assign drop_count   = drop_cnt_reg;
    assign orphan_count = orphan_cnt_reg;
`else
    assign drop_count   = '0;
    assign orphan_count = '0;
`endif

endmodule

// File: tb/tb_ddr2_sys_st_channel_pkt_adapter.sv
// Scoreboard bench for the channel packet adapter: a packet-level reference model predicts
// forwarded beats and counter values; an output monitor checks order, latency and stall stability.
module tb_ddr2_sys_st_channel_pkt_adapter;

    localparam int DW = 8, ICW = 8, OCW = 2, MAXC = 3, CW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_ready, in_valid;
    logic [DW-1:0]  in_data;
    logic [ICW-1:0] in_channel;
    logic           in_sop, in_eop;
    logic           out_ready, out_valid;
    logic [DW-1:0]  out_data;
    logic [OCW-1:0] out_channel;
    logic           out_sop, out_eop;
    logic [CW-1:0]  drop_count, orphan_count;

    ddr2_sys_st_channel_pkt_adapter #(
        .DATA_W(DW), .IN_CHANNEL_W(ICW), .OUT_CHANNEL_W(OCW), .MAX_CHANNEL(MAXC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data), .in_channel(in_channel),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .drop_count(drop_count), .orphan_count(orphan_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]  data;
        logic [OCW-1:0] ch;
        logic           sop, eop;
        int             acc;
        bit             lat;
    } beat_t;

    beat_t exp_q[$];
    int n_chk = 0, n_pass = 0;

    bit             m_open = 0, m_pass = 0;
    logic [OCW-1:0] m_chan = '0;
    int             m_drops = 0, m_orphans = 0;
    bit             rand_ready = 0;

    function automatic void chk(string name, longint got, longint req);
        n_chk++;
        if (got == req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    endfunction

    // Reference model: packet-level view of which beats survive and which events are counted.
    always @(negedge clk) begin
        beat_t b;
        #1;
        if (reset) begin
            exp_q.delete();
            m_open = 0; m_pass = 0; m_drops = 0; m_orphans = 0;
        end else if (in_valid) begin
            if (m_open && !m_pass) chk("in_ready_in_drop", in_ready, 1);
            if (in_ready) begin
                b.data = in_data; b.eop = in_eop; b.acc = cyc; b.lat = (exp_q.size() == 0);
                if (in_sop) begin
                    if (in_channel <= MAXC) begin
                        m_pass = 1; m_chan = in_channel[OCW-1:0];
                        b.ch = m_chan; b.sop = 1'b1;
                        exp_q.push_back(b);
                    end else begin
                        m_pass = 0; m_drops++;
                    end
                    m_open = !in_eop;
                end else if (!m_open) begin
                    m_orphans++;
                end else begin
                    if (m_pass) begin
                        b.ch = m_chan; b.sop = 1'b0;
                        exp_q.push_back(b);
                    end
                    if (in_eop) m_open = 0;
                end
            end
        end
    end

    // Output monitor
    bit          prev_stall = 0;
    logic [11:0] prev_out = '0;
    always @(negedge clk) begin
        logic [11:0] cur;
        beat_t e;
        if (reset) begin
            prev_stall = 0;
        end else if (out_valid) begin
            cur = {out_data, out_channel, out_sop, out_eop};
            if (prev_stall) chk("stall_hold", cur, prev_out);
            else if (exp_q.size() == 0) chk("out_valid_no_expected", out_valid, 0);
            else if (exp_q[0].lat) chk("latency", cyc - exp_q[0].acc, 1);
            if (out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("beat data=%02h ch=%0d sop=%0b eop=%0b", out_data, out_channel, out_sop, out_eop);
                chk("beat", cur, {e.data, e.ch, e.sop, e.eop});
            end
            prev_stall = !out_ready;
            prev_out   = cur;
        end else begin
            if (prev_stall) chk("stall_valid_hold", out_valid, 1);
            prev_stall = 0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [ICW-1:0] ch, input logic s, input logic e);
        bit acc = 0;
        in_valid = 1'b1; in_data = d; in_channel = ch; in_sop = s; in_eop = e;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic [ICW-1:0] ch, input int len, input int gap_max);
        for (int i = 0; i < len; i++) begin
            send(DW'($urandom), (i == 0) ? ch : ICW'($urandom_range(0, 15)), i == 0, i == len - 1);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic check_counts(input string tag);
        int exp_d, exp_o;
`ifdef ST_CHAN_ADAPT_DROP_CNT_EN
        exp_d = m_drops; exp_o = m_orphans;
`else
        exp_d = 0; exp_o = 0;
`endif
        idle(2);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_drop_count"}, drop_count, exp_d);
        chk({tag, "_orphan_count"}, orphan_count, exp_o);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_channel"}, out_channel, 0);
        chk({tag, "_out_sop"}, out_sop, 0);
        chk({tag, "_out_eop"}, out_eop, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
        chk({tag, "_orphan_count"}, orphan_count, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        bit pat [0:5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_channel = '0; in_sop = 1'b0; in_eop = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;

        // 1: back-to-back packet on channel 2
        pkt(8'd2, 4, 0);
        check_counts("t1");

        // 2: dropped channel-5 packet then channel-1 packet
        pkt(8'd5, 3, 0);
        pkt(8'd1, 2, 0);
        check_counts("t2");

        // 3: mid-packet channel field is ignored
        send(8'hA0, 8'd0, 1'b1, 1'b0);
        send(8'hA1, 8'd0, 1'b0, 1'b0);
        send(8'hA2, 8'd7, 1'b0, 1'b0);
        send(8'hA3, 8'd3, 1'b0, 1'b1);
        check_counts("t3");

        // 4: backpressure pattern during a 6-beat stream
        fork
            pkt(8'd1, 6, 0);
            begin
                for (int i = 0; i < 6; i++) begin
                    out_ready = pat[i];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        check_counts("t4");

        // 5: orphan beat then single-beat packet on channel 9
        send(8'h55, 8'd1, 1'b0, 1'b0);
        send(8'h66, 8'd9, 1'b1, 1'b1);
        check_counts("t5");
        pkt(8'd3, 1, 0);
        check_counts("t5b");

        // 6: reset in the middle of a pass-through packet
        send(8'h10, 8'd3, 1'b1, 1'b0);
        send(8'h11, 8'd3, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h12; in_channel = 8'd3; in_sop = 1'b0; in_eop = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        pkt(8'd2, 3, 0);
        check_counts("t6");

        // Randomized: well-formed packets, then free-form beats, under random backpressure
        rand_ready = 1;
        for (int p = 0; p < 40; p++) begin
            pkt(ICW'($urandom_range(0, 7)), $urandom_range(1, 5), $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) send(DW'($urandom), ICW'($urandom_range(0, 7)), 1'b0, 1'b0);
        end
        for (int k = 0; k < 80; k++) begin
            send(DW'($urandom), ICW'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_ready = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        check_counts("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
